// File: rtl/scan_pkg.sv
// Shared types and helpers for the scanner ring controller.
package scan_pkg;

    // Channel state codes; values 5..7 never get stored and are read as LOWPWR.
    typedef enum logic [2:0] {
        ST_LOWPWR  = 3'd0,
        ST_STANDBY = 3'd1,
        ST_SCAN    = 3'd2,
        ST_IDLE    = 3'd3,
        ST_XFER    = 3'd4
    } scan_state_t;

    // Fill percentage, floor(count*100/depth), through a 14-bit product.
    function automatic logic [6:0] pct_of(input logic [6:0] count, input logic [6:0] depth);
        logic [13:0] prod;
        prod = 14'(count) * 14'd100;
        return 7'(prod / 14'(depth));
    endfunction

    // Unused codes alias to LOWPWR so a stray value can still be woken.
    function automatic logic is_lowpwr(input logic [2:0] s);
        return (s == ST_LOWPWR) || (s > ST_XFER);
    endfunction

endpackage

// File: rtl/scanner_channel.sv
// One scanner: holds its state and item count, and acts on commands
// decoded by the ring arbiter. Everything advances only on tick.
module scanner_channel
    import scan_pkg::*;
#(
    parameter int BUF_DEPTH = 10,
    parameter int CW        = 4,
    parameter bit INIT_SCAN = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          inc,
    input  logic          wake,
    input  logic          start,
    input  logic          handoff_out,
    input  logic          flush,
    output logic [2:0]    state,
    output logic [CW-1:0] count
);

    scan_state_t   state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;

    // State and count registers, gated by tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= INIT_SCAN ? ST_SCAN : ST_LOWPWR;
            count_reg <= '0;
        end else if (tick) begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next-state and count rules for this channel.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_SCAN: begin
                if (handoff_out)
                    state_next = ST_IDLE;
                else if (inc && count_reg != CW'(BUF_DEPTH))
                    count_next = count_reg + CW'(1);
            end
            ST_IDLE: begin
                if (flush)
                    state_next = ST_XFER;
            end
            ST_XFER: begin
                // Once started, draining ignores flush.
                if (count_reg != '0)
                    count_next = count_reg - CW'(1);
                else
                    state_next = ST_LOWPWR;
            end
            ST_STANDBY: begin
                if (start)
                    state_next = ST_SCAN;
            end
            default: begin
                state_next = ST_LOWPWR;
                if (wake)
                    state_next = ST_STANDBY;
            end
        endcase
    end

    assign state = state_reg;
    assign count = count_reg;

endmodule

// File: rtl/scanner_array_ctrl.sv
// Ring arbiter for N_SCAN scanners: fills the active channel, wakes its
// successor near full, hands off when the successor is ready, and flags
// a stall when the active buffer is full with nowhere to go.
module scanner_array_ctrl
    import scan_pkg::*;
#(
    parameter int N_SCAN    = 2,
    parameter int BUF_DEPTH = 10,
    parameter int STBY_PCT  = 80,
    localparam int AW = $clog2(N_SCAN),
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  flush,
    output logic [3*N_SCAN-1:0]   state_o,
    output logic [7*N_SCAN-1:0]   pct_o,
    output logic [AW-1:0]         active_o,
    output logic                  stall_o
);

    logic [2:0]    chan_state [N_SCAN];
    logic [CW-1:0] chan_count [N_SCAN];

    logic [AW-1:0] active_reg;
    logic          stall_reg;

    logic [AW-1:0] nxt_idx;
    logic [CW-1:0] act_count;
    logic [CW-1:0] post_count;
    logic [2:0]    nxt_state;
    logic          act_full;
    logic          wake_ok;
    logic          handoff;

    // Decode ring decisions from the active channel and its successor.
    always_comb begin
        nxt_idx    = (active_reg == AW'(N_SCAN - 1)) ? '0 : active_reg + AW'(1);
        act_count  = chan_count[active_reg];
        nxt_state  = chan_state[nxt_idx];
        act_full   = (act_count == CW'(BUF_DEPTH));
        post_count = act_full ? act_count : act_count + CW'(1);
        // Re-evaluated every tick so a crossing missed while the successor
        // was busy still wakes it once it reaches LOWPWR.
        wake_ok    = (pct_of(7'(post_count), 7'(BUF_DEPTH)) >= 7'(STBY_PCT)) &&
                     is_lowpwr(nxt_state);
        handoff    = act_full && (nxt_state == ST_STANDBY);
    end

    // Active-index and stall registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg <= '0;
            stall_reg  <= 1'b0;
        end else if (tick) begin
            if (handoff)
                active_reg <= nxt_idx;
            stall_reg <= act_full && !handoff;
        end
    end

    generate
        for (genvar gi = 0; gi < N_SCAN; gi++) begin : g_chan
            scanner_channel #(
                .BUF_DEPTH (BUF_DEPTH),
                .CW        (CW),
                .INIT_SCAN (gi == 0)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .tick        (tick),
                .inc         (active_reg == AW'(gi)),
                .wake        (wake_ok && (nxt_idx == AW'(gi))),
                .start       (handoff && (nxt_idx == AW'(gi))),
                .handoff_out (handoff && (active_reg == AW'(gi))),
                .flush       (flush),
                .state       (chan_state[gi]),
                .count       (chan_count[gi])
            );

            assign state_o[3*gi +: 3] = chan_state[gi];
            assign pct_o[7*gi +: 7]   = pct_of(7'(chan_count[gi]), 7'(BUF_DEPTH));
        end
    endgenerate

    assign active_o = active_reg;
    assign stall_o  = stall_reg;

endmodule

// File: tb/tb_scanner_array_ctrl.sv
// Scoreboard bench: the driver steps a rule-level model and queues the
// expected outputs; a monitor compares them one edge later.
module tb_scanner_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: two scanners, depth 10.
    logic        rst_a = 1'b1, tick_a = 1'b0, flush_a = 1'b0;
    logic [5:0]  state_a;
    logic [13:0] pct_a;
    logic [0:0]  active_a;
    logic        stall_a;

    // Instance B: three scanners, depth 7.
    logic        rst_b = 1'b1, tick_b = 1'b0, flush_b = 1'b0;
    logic [8:0]  state_b;
    logic [20:0] pct_b;
    logic [1:0]  active_b;
    logic        stall_b;

    scanner_array_ctrl #(.N_SCAN(2), .BUF_DEPTH(10), .STBY_PCT(80)) dut_a (
        .clk(clk), .reset(rst_a), .tick(tick_a), .flush(flush_a),
        .state_o(state_a), .pct_o(pct_a), .active_o(active_a), .stall_o(stall_a)
    );

    scanner_array_ctrl #(.N_SCAN(3), .BUF_DEPTH(7), .STBY_PCT(80)) dut_b (
        .clk(clk), .reset(rst_b), .tick(tick_b), .flush(flush_b),
        .state_o(state_b), .pct_o(pct_b), .active_o(active_b), .stall_o(stall_b)
    );

    typedef struct {
        int          dut;
        logic [8:0]  st;
        logic [20:0] pct;
        logic [1:0]  act;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: channel states as plain codes
    // (0 lowpwr, 1 standby, 2 scan, 3 idle, 4 xfer).
    int m_n, m_d, m_s;
    int m_st[3];
    int m_cnt[3];
    int m_act;
    bit m_stall;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i]  = 0;
            m_cnt[i] = 0;
        end
        m_st[0] = 2;
        m_act   = 0;
        m_stall = 0;
    endtask

    task automatic model_step(input bit rst, input bit tk, input bit fl);
        int ns[3];
        int nc[3];
        int a, n;
        if (rst) begin
            model_reset();
        end else if (tk) begin
            a = m_act;
            n = (a + 1) % m_n;
            for (int i = 0; i < 3; i++) begin
                ns[i] = m_st[i];
                nc[i] = m_cnt[i];
            end
            // Drain side: every non-active channel acts on its own.
            for (int i = 0; i < m_n; i++) begin
                if (i != a) begin
                    if (m_st[i] == 3 && fl) ns[i] = 4;
                    else if (m_st[i] == 4) begin
                        if (m_cnt[i] > 0) nc[i] = m_cnt[i] - 1;
                        else ns[i] = 0;
                    end
                end
            end
            // Fill side.
            if (m_cnt[a] == m_d) begin
                if (m_st[n] == 1) begin
                    ns[a]   = 3;
                    ns[n]   = 2;
                    m_act   = n;
                    m_stall = 0;
                end else begin
                    m_stall = 1;
                    if (m_st[n] == 0) ns[n] = 1;
                end
            end else begin
                nc[a]   = m_cnt[a] + 1;
                m_stall = 0;
                if ((nc[a] * 100) / m_d >= m_s && m_st[n] == 0) ns[n] = 1;
            end
            for (int i = 0; i < 3; i++) begin
                m_st[i]  = ns[i];
                m_cnt[i] = nc[i];
            end
        end
    endtask

    // Drive one clock of inputs to the selected instance and queue the expectation.
    task automatic cycle(input int dut, input bit rst, input bit tk, input bit fl);
        exp_t e;
        @(negedge clk);
        if (dut == 0) begin
            rst_a = rst; tick_a = tk; flush_a = fl;
            rst_b = 1'b0; tick_b = 1'b0; flush_b = 1'b0;
        end else begin
            rst_b = rst; tick_b = tk; flush_b = fl;
            rst_a = 1'b0; tick_a = 1'b0; flush_a = 1'b0;
        end
        model_step(rst, tk, fl);
        e.dut = dut;
        e.st  = '0;
        e.pct = '0;
        for (int i = 0; i < m_n; i++) begin
            e.st[3*i +: 3]  = 3'(m_st[i]);
            e.pct[7*i +: 7] = 7'((m_cnt[i] * 100) / m_d);
        end
        e.act   = 2'(m_act);
        e.stall = m_stall;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: after each edge, compare the DUT against the queued expectation.
    exp_t       mon_e;
    logic [8:0] mon_st;
    logic [20:0] mon_pct;
    logic [1:0] mon_act;
    logic       mon_stall;
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.dut == 0) begin
                mon_st = {3'b0, state_a}; mon_pct = {7'b0, pct_a};
                mon_act = {1'b0, active_a}; mon_stall = stall_a;
            end else begin
                mon_st = state_b; mon_pct = pct_b;
                mon_act = active_b; mon_stall = stall_b;
            end
            checks++;
            if (mon_st !== mon_e.st || mon_pct !== mon_e.pct ||
                mon_act !== mon_e.act || mon_stall !== mon_e.stall) begin
                errors++;
                $display("FAIL scoreboard dut%0d t=%0t: state=%h pct=%h active=%0d stall=%b expected state=%h pct=%h active=%0d stall=%b",
                         mon_e.dut, $time, mon_st, mon_pct, mon_act, mon_stall,
                         mon_e.st, mon_e.pct, mon_e.act, mon_e.stall);
            end
            $display("txn dut%0d t=%0t state=%h pct=%h active=%0d stall=%b",
                     mon_e.dut, $time, mon_st, mon_pct, mon_act, mon_stall);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- Instance A: N=2, depth 10 ----------------
        m_n = 2; m_d = 10; m_s = 80;
        model_reset();
        repeat (2) cycle(0, 1, 0, 0);
        settle();
        chk("a_reset_state", int'(state_a), 6'b000_010);
        chk("a_reset_pct", int'(pct_a), 0);
        chk("a_reset_active", int'(active_a), 0);
        chk("a_reset_stall", int'(stall_a), 0);

        repeat (8) cycle(0, 0, 1, 0);
        settle();
        chk("a_pct80", int'(pct_a[6:0]), 80);
        chk("a_ch1_standby", int'(state_a[5:3]), 1);

        repeat (2) cycle(0, 0, 1, 0);
        settle();
        chk("a_pct100", int'(pct_a[6:0]), 100);

        cycle(0, 0, 1, 0);
        settle();
        chk("a_handoff_state", int'(state_a), 6'b010_011);
        chk("a_handoff_active", int'(active_a), 1);
        chk("a_handoff_ch1pct", int'(pct_a[13:7]), 0);

        repeat (13) cycle(0, 0, 1, 0);
        settle();
        chk("a_stall", int'(stall_a), 1);
        chk("a_stall_ch1pct", int'(pct_a[13:7]), 100);

        cycle(0, 0, 1, 1);
        settle();
        chk("a_ch0_xfer", int'(state_a[2:0]), 4);

        repeat (13) cycle(0, 0, 1, 1);
        settle();
        chk("a_return_state", int'(state_a), 6'b011_010);
        chk("a_return_stall", int'(stall_a), 0);
        chk("a_return_active", int'(active_a), 0);

        // Put ch1 mid-drain, then reset with tick held high.
        repeat (3) cycle(0, 0, 1, 1);
        cycle(0, 1, 1, 1);
        settle();
        chk("a_midxfer_reset_state", int'(state_a), 6'b000_010);
        chk("a_midxfer_reset_pct", int'(pct_a), 0);
        repeat (5) cycle(0, 0, 0, 1);

        for (int k = 0; k < 400; k++)
            cycle(0, ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1);

        // ---------------- Instance B: N=3, depth 7 ----------------
        m_n = 3; m_d = 7; m_s = 80;
        model_reset();
        repeat (2) cycle(1, 1, 0, 0);
        repeat (3) cycle(1, 0, 1, 1);
        settle();
        chk("b_pct42", int'(pct_b[6:0]), 42);

        repeat (60) cycle(1, 0, 1, 1);
        for (int k = 0; k < 400; k++)
            cycle(1, ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 2) != 0);

        settle();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scanner_array_ctrl.md
# scanner_array_ctrl

Parametrised controller for a ring of N_SCAN document scanners sharing one buffer-handoff protocol. It generalises the fixed two-scanner controller to any channel count and buffer depth. It adds a programmable standby threshold, an explicit tick enable instead of a divided clock, and stall reporting when handoff is blocked. It sits between the board top (tick generator, switches) and per-channel display decoders.

## Interface
- N_SCAN, default 2: number of scanners, ≥2.
- BUF_DEPTH, default 10: buffer capacity per scanner, in items (1..100).
- STBY_PCT, default 80: fill percentage (1..99) at which the next scanner is woken.
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- tick  in  1  single-cycle enable; all state/count updates occur only on clk edges with tick=1.
- flush  in  1  level; permits IDLE scanners to begin transfer.
- state_o  out  3×N_SCAN  per-channel state code, channel i at bits [3i+2:3i].
- pct_o  out  7×N_SCAN  per-channel fill percentage, floor(count×100/BUF_DEPTH), range 0..100.
- active_o  out  $clog2(N_SCAN)  index of the scanning channel.
- stall_o  out  1  active scanner is full and cannot hand off.

## Operation
- State codes: LOWPWR=0, STANDBY=1, SCAN=2, IDLE=3, XFER=4. Codes 5–7 are unused; treat them as LOWPWR.
- Reset values:
  - channel 0: SCAN; all others: LOWPWR.
  - all counts 0, active_o=0, stall_o=0.
- next(i) = (i+1) mod N_SCAN.
- Exactly one channel is in SCAN at any time.
- Per tick, for the active channel a in SCAN:
  - If count<BUF_DEPTH: count+1.
  - If the post-increment pct ≥ STBY_PCT and next(a) is LOWPWR: next(a) becomes STANDBY on the same edge.
  - If count==BUF_DEPTH (pre-tick) and next(a) is STANDBY: a becomes IDLE, next(a) becomes SCAN, and active_o becomes next(a). The new channel's count is not incremented on the handoff edge.
  - If count==BUF_DEPTH and next(a) is not STANDBY: hold all state and count; stall_o=1.
  - If the STBY_PCT crossing was missed because next(a) was busy, STANDBY is entered on the first tick where next(a) is LOWPWR.
- IDLE channel: on a tick with flush=1, it enters XFER (count unchanged on that edge).
- XFER channel:
  - count−1 per tick if count>0.
  - On a tick where count==0, it enters LOWPWR.
  - flush dropping mid-transfer does not pause or abort XFER.
- STANDBY and LOWPWR channels: count is held.
- Several channels may be in IDLE/XFER simultaneously; each evaluates independently on the same tick.
- Width rules:
  - count is $clog2(BUF_DEPTH+1) bits and saturates at BUF_DEPTH and at 0.
  - pct uses a 14-bit intermediate product and constant division, combinational from registered count.

## Timing
- All outputs are registered state or combinational from registered state; there are no combinational input→output paths.
- Latency: one clk edge after a tick for all updates.
- tick=0: no change except reset.
- reset has priority over tick and flush. Asserted mid-XFER or mid-stall, it returns every output to its reset value on the next edge.
- stall_o updates on the same edge as the hold decision, and clears on the edge where the handoff occurs.

## Structure
- Package scan_pkg: state enum (3-bit), the state-code constants, and a function pct_of(count, depth).
- Sub-module scanner_channel: one per channel. It holds state and count, and takes decoded commands (inc, wake, start, handoff_out, flush) from the ring arbiter in scanner_array_ctrl.
- The top generate-loop instantiates N_SCAN channels and the active-index register.

## Test plan
- N_SCAN=2, BUF_DEPTH=10, STBY_PCT=80; reset → state_o={LOWPWR,SCAN}, pct_o all 0, active_o=0, stall_o=0.
- 8 ticks → ch0 count 8, pct 80; ch1 STANDBY on the 8th tick edge. Ticks 9–10 → ch0 pct 100. 11th tick → ch0 IDLE, ch1 SCAN, active_o=1, ch1 pct 0.
- Flush held 0; 10 more ticks fill ch1, then 3 further ticks → stall_o=1, all states and counts unchanged.
- Assert flush during the stall → ch0 XFER on the next tick and decrements 100→0 over 10 ticks. One more tick → LOWPWR. Next tick → ch0 STANDBY. Next tick → ch1 IDLE, ch0 SCAN, stall_o=0.
- N_SCAN=3, BUF_DEPTH=7: the handoff ring runs 0→1→2→0 with flush=1 throughout, and active_o wraps 2→0. pct for count 3 = 42.
- Reset asserted mid-XFER with tick=1 → all outputs return to reset values on the next edge. tick=0 for 5 cycles → no output changes.
